// File: rtl/pc_sequencer_if.sv
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of the RAM-side, executor-side and control signals of
//                the program-counter sequencer. The slave modport is the
//                sequencer's view; the master modport is the environment's.
//                Macro SINGLE_STEP_EN adds the step_mode / step controls.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              run;
  logic              cmd_start;
  logic [7:0]        instr_0;
  logic [7:0]        instr_1;
  logic [7:0]        instr_2;
  logic              exec_done;
  logic              zero_flag;
  logic [ADDR_W-1:0] pc;
  logic              exec_valid;
  logic [7:0]        exec_opcode;
  logic [7:0]        exec_op1;
  logic [7:0]        exec_op2;
  logic              halted;
`ifdef SINGLE_STEP_EN
  logic              step_mode;
  logic              step;

  modport slave (
    input  run, cmd_start, instr_0, instr_1, instr_2, exec_done, zero_flag,
    input  step_mode, step,
    output pc, exec_valid, exec_opcode, exec_op1, exec_op2, halted
  );
  modport master (
    output run, cmd_start, instr_0, instr_1, instr_2, exec_done, zero_flag,
    output step_mode, step,
    input  pc, exec_valid, exec_opcode, exec_op1, exec_op2, halted
  );
`else
  modport slave (
    input  run, cmd_start, instr_0, instr_1, instr_2, exec_done, zero_flag,
    output pc, exec_valid, exec_opcode, exec_op1, exec_op2, halted
  );
  modport master (
    output run, cmd_start, instr_0, instr_1, instr_2, exec_done, zero_flag,
    input  pc, exec_valid, exec_opcode, exec_op1, exec_op2, halted
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program counter and instruction dispatch. Drives the program
//                RAM address, captures the three-byte instruction on the RAM
//                start strobe, issues it to the executor with a valid/done
//                handshake and resolves the next address (sequential, JMP,
//                JZ or HALT). Optional macro SINGLE_STEP_EN adds a PAUSE
//                state controlled by step_mode / step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int unsigned             ADDR_W   = 9,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  pc_sequencer_if.slave   bus
);

  localparam logic [7:0] c_OP_HALT = 8'hFF;
  localparam logic [7:0] c_OP_JMP  = 8'hC0;
  localparam logic [7:0] c_OP_JZ   = 8'hC1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_EXEC    = 3'd3,
    S_ADVANCE = 3'd4,
    S_HALT    = 3'd5
`ifdef SINGLE_STEP_EN
    ,S_PAUSE  = 3'd6
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [7:0]        opc_q, opc_d;
  logic [7:0]        op1_q, op1_d;
  logic [7:0]        op2_q, op2_d;
`ifdef SINGLE_STEP_EN
  logic              pend_q, pend_d;
  logic              w_have_cmd;
`endif

  logic [8:0]        w_target9;
  logic [ADDR_W-1:0] w_target;
  logic [1:0]        w_len;
  logic [ADDR_W-1:0] w_seq;
  logic              w_take;

  // Jump target and sequential successor derived from the latched instruction
  assign w_target9 = {op1_q[0], op2_q};
  assign w_target  = ADDR_W'(w_target9);
  assign w_seq     = pc_q + ADDR_W'(w_len);
  assign w_take    = (opc_q == c_OP_JMP) || ((opc_q == c_OP_JZ) && bus.zero_flag);

  // Instruction length from the opcode's top two bits
  always_comb begin
    w_len = 2'd3;
    case (opc_q[7:6])
      2'b00:   w_len = 2'd1;
      2'b01:   w_len = 2'd2;
      default: w_len = 2'd3;
    endcase
  end

  // Next-state and next-register computation
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    opc_d   = opc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
`ifdef SINGLE_STEP_EN
    pend_d     = pend_q;
    w_have_cmd = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (bus.cmd_start) begin
          opc_d   = bus.instr_0;
          op1_d   = bus.instr_1;
          op2_d   = bus.instr_2;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // a done strobe here is ignored; the executor only just got the op
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (opc_q == c_OP_HALT) begin
            state_d = S_HALT;
          end else if (w_take) begin
            // self-jump never changes the address, so the RAM would never
            // re-fetch; stop cleanly instead of deadlocking
            if (w_target == pc_q) begin
              state_d = S_HALT;
            end else begin
              npc_d   = w_target;
              state_d = S_ADVANCE;
            end
          end else begin
            npc_d   = w_seq;
            state_d = S_ADVANCE;
          end
        end
      end
      S_ADVANCE: begin
        pc_d = npc_q;
`ifdef SINGLE_STEP_EN
        if (bus.step_mode)  state_d = S_PAUSE;
        else if (bus.run)   state_d = S_FETCH;
        else                state_d = S_IDLE;
`else
        if (bus.run) state_d = S_FETCH;
        else         state_d = S_IDLE;
`endif
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        // the RAM may deliver the new instruction while paused; hold it
        if (bus.cmd_start && !pend_q) begin
          opc_d  = bus.instr_0;
          op1_d  = bus.instr_1;
          op2_d  = bus.instr_2;
          pend_d = 1'b1;
        end
        w_have_cmd = pend_q | bus.cmd_start;
        if (bus.step) begin
          pend_d  = 1'b0;
          state_d = w_have_cmd ? S_ISSUE : S_FETCH;
        end else if (!bus.run) begin
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
`endif
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      opc_q   <= 8'h00;
      op1_q   <= 8'h00;
      op2_q   <= 8'h00;
`ifdef SINGLE_STEP_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      opc_q   <= opc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
`ifdef SINGLE_STEP_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign bus.pc          = pc_q;
  assign bus.exec_valid  = (state_q == S_ISSUE);
  assign bus.exec_opcode = opc_q;
  assign bus.exec_op1    = op1_q;
  assign bus.exec_op2    = op2_q;
  assign bus.halted      = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter and instruction-dispatch stage that sits directly downstream of the program RAM read port. It drives the RAM byte address and captures the three-byte instruction window when the RAM pulses its start strobe. It then hands the instruction to the executor with a valid/done handshake and computes the next address (sequential, jump, conditional jump or halt). Changing the address is what re-arms the RAM's fetch FSM, so this block owns all control-flow decisions.

Parameters:
ADDR_W, 9, byte address width; must match the program RAM address width.
RESET_PC, 0, pc value loaded on reset.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
run  in  1  level; allows leaving IDLE.
cmd_start  in  1  one-cycle strobe from the RAM; instr_0..2 are valid in the same cycle.
instr_0  in  8  opcode byte.
instr_1  in  8  operand 1.
instr_2  in  8  operand 2.
exec_done  in  1  one-cycle strobe from the executor.
zero_flag  in  1  executor Z flag, sampled with exec_done.
pc  out  ADDR_W  byte address to the program RAM.
exec_valid  out  1  one-cycle pulse; exec_* fields are valid.
exec_opcode  out  8  latched opcode.
exec_op1  out  8  latched operand 1.
exec_op2  out  8  latched operand 2.
halted  out  1  sticky halt indicator.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; exec_valid=0; exec_opcode/op1/op2=0; halted=0.
  - State=IDLE; internal next-pc register=RESET_PC.
- States: IDLE, FETCH, ISSUE, EXEC, ADVANCE, HALT.
- IDLE: run=1 -> FETCH.
- FETCH: cmd_start=1 -> latch instr_0..2 into exec_*; go to ISSUE. cmd_start in any other state is ignored.
- ISSUE: exec_valid=1 for exactly this cycle; go to EXEC.
- EXEC: wait for exec_done. exec_done is ignored outside EXEC. On exec_done, compute next pc from the latched opcode and the zero_flag sampled that cycle:
  - 8'hFF HALT: go to HALT; pc unchanged.
  - 8'hC0 JMP: target = {op1[0], op2}.
  - 8'hC1 JZ: if zero_flag=1, target = {op1[0], op2}; else pc+3.
  - Otherwise, length comes from opcode[7:6]: 00 -> 1 byte, 01 -> 2 bytes, 1x -> 3 bytes. Next pc = pc+len modulo 2^ADDR_W (wraps 511 -> 0).
  - Jump target equal to the current pc: treated as HALT. The RAM only re-fetches on an address change, so a self-jump would otherwise deadlock.
- ADVANCE: pc<=next pc. If run=1 -> FETCH, else -> IDLE. Dropping run mid-instruction completes the current instruction first.
- HALT: halted=1; pc held. Exit only by reset.
- Latency:
  - cmd_start at edge N -> exec_valid high in cycle N+1.
  - exec_done at edge M -> pc updated at edge M+1.
- The executor must not assert exec_done in the exec_valid cycle; such a strobe is ignored.
- Reset mid-operation aborts without completing. No exec_valid is emitted after reset until a fresh cmd_start arrives.

Optional Feature:
SINGLE_STEP_EN:
- Defined: adds inputs step_mode (level) and step (one-cycle pulse). With step_mode=1, ADVANCE goes to a PAUSE state after updating pc. PAUSE -> FETCH on step=1; PAUSE -> IDLE if run=0. A cmd_start arriving in PAUSE is held in a one-entry pending flag, with its bytes latched, and consumed on step. With step_mode=0, behaviour is identical to the undefined case.
- Undefined: no ports, no PAUSE state.

Test Plan:
1. Reset: hold rst=0 mid-EXEC -> pc=0, exec_valid=0, halted=0 immediately (asynchronous); after release, no exec_valid until run=1 and cmd_start.
2. Sequential: run=1; cmd_start with 12/34/56 at pc=0 -> exec_valid next cycle, exec_opcode=8'h12; exec_done -> pc=1 one cycle later. Repeat with 8'h45 -> pc+2, and 8'h85 -> pc+3.
3. Wrap: pc=9'h1FF; opcode 8'h85; exec_done -> pc=9'h002.
4. Jumps:
   - JMP C0/01/23 -> pc=9'h123.
   - JZ C1/00/40 with zero_flag=0 at pc=0x10 -> pc=0x13.
   - Same JZ with zero_flag=1 -> pc=0x040.
5. Halt:
   - 8'hFF -> halted=1, pc unchanged; later cmd_start and exec_done pulses produce no exec_valid.
   - JMP to its own address -> halted=1.
6. Handshake abuse:
   - cmd_start during EXEC is ignored; exec_* fields unchanged.
   - exec_done in the ISSUE cycle is ignored; the FSM waits for the next exec_done.
   - run dropped in EXEC -> instruction completes, pc advances, state=IDLE.
